pillar_collide: RTL and testbench

//  Downstream of the bird/pillar physics block. Consumes bird height y and gap centres p1/p2.

---
 rtl/pillar_collide_pkg.sv | 46 ++++
 rtl/pillar_collide_if.sv | 38 +++
 rtl/pillar_collide_bcd_counter3.sv | 29 ++
 rtl/pillar_collide.sv | 181 ++++++++++++++++++
 tb/tb_pillar_collide.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pillar_collide_pkg.sv
// Shared types and default geometry for the pillar scroll / collision / score block.
// State encoding, screen and ground constants, and the BCD digit helpers used by the score counter.
package pillar_collide_pkg;

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DYING = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam int SCREEN_W_DEF  = 640;
  localparam int BIRD_X_DEF    = 160;
  localparam int BIRD_W_DEF    = 16;
  localparam int PIPE_W_DEF    = 48;
  localparam int GAP_HALF_DEF  = 60;
  localparam int SCROLL_DEF    = 2;
  localparam int DIE_TICKS_DEF = 60;
  localparam int GROUND_Y      = 0;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [11:0] BCD_MAX = 12'h999;

  // Ripple a +1 through three BCD digits, ones first.
  function automatic logic [11:0] bcd_next(input logic [11:0] v);
    logic [11:0] r;
    logic        carry;
    bcd_digit_t  d;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d = r[i*4 +: 4];
      if (carry) begin
        if (d == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = d + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pillar_collide_if.sv
// Bundle between the physics/render side (master) and pillar_collide (slave).
// HISCORE_EN adds the hiscore_bcd return signal.
interface pillar_collide_if;
  // Inputs are levels except tick, a one-cycle strobe; outputs are registered pulses/levels.
  logic        tick;
  logic        flap;
  logic [8:0]  bird_y;
  logic [8:0]  p1;
  logic [8:0]  p2;
  logic [9:0]  px_a;
  logic [9:0]  px_b;
  logic [1:0]  state;
  logic        freeze;
  logic        hit;
  logic        score_inc;
  logic [11:0] score_bcd;
`ifdef HISCORE_EN
  logic [11:0] hiscore_bcd;

  modport master (
    output tick, flap, bird_y, p1, p2,
    input  px_a, px_b, state, freeze, hit, score_inc, score_bcd, hiscore_bcd
  );
  modport slave (
    input  tick, flap, bird_y, p1, p2,
    output px_a, px_b, state, freeze, hit, score_inc, score_bcd, hiscore_bcd
  );
`else
  modport master (
    output tick, flap, bird_y, p1, p2,
    input  px_a, px_b, state, freeze, hit, score_inc, score_bcd
  );
  modport slave (
    input  tick, flap, bird_y, p1, p2,
    output px_a, px_b, state, freeze, hit, score_inc, score_bcd
  );
`endif
endinterface

// File: rtl/pillar_collide_bcd_counter3.sv
// Three-digit BCD score counter: synchronous clear, +1 on inc, saturates at 999.
// inc_done pulses one cycle only when the value actually changed.
module bcd_counter3
  import pillar_collide_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [11:0] value,
  output logic        inc_done
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value    <= 12'h000;
      inc_done <= 1'b0;
    end else begin
      inc_done <= 1'b0;
      if (clr) begin
        value <= 12'h000;
      end else if (inc && (value != BCD_MAX)) begin
        value    <= bcd_next(value);
        inc_done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pillar_collide.sv
// Pillar scroller, bird collision detector, round FSM and BCD score for the flappy game.
// Define HISCORE_EN to add a high-score register latched on entry to OVER.
module pillar_collide
  import pillar_collide_pkg::*;
#(
  parameter int SCREEN_W  = SCREEN_W_DEF,
  parameter int BIRD_X    = BIRD_X_DEF,
  parameter int BIRD_W    = BIRD_W_DEF,
  parameter int PIPE_W    = PIPE_W_DEF,
  parameter int GAP_HALF  = GAP_HALF_DEF,
  parameter int SCROLL    = SCROLL_DEF,
  parameter int DIE_TICKS = DIE_TICKS_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  pillar_collide_if.slave bus
);

  localparam logic [9:0] SCREEN_X = 10'(SCREEN_W);
  localparam logic [9:0] START_B  = 10'(SCREEN_W / 2);
  localparam logic [9:0] SCROLL_X = 10'(SCROLL);

  localparam logic signed [10:0] BIRD_X_S   = 11'(BIRD_X);
  localparam logic signed [10:0] BIRD_W_S   = 11'(BIRD_W);
  localparam logic signed [10:0] PIPE_W_S   = 11'(PIPE_W);
  localparam logic signed [10:0] GAP_HALF_S = 11'(GAP_HALF);
  localparam logic signed [10:0] GROUND_S   = 11'(GROUND_Y);

  localparam int              DIE_W    = (DIE_TICKS > 1) ? $clog2(DIE_TICKS) : 1;
  localparam logic [DIE_W-1:0] DIE_LAST = DIE_W'(DIE_TICKS - 1);

  state_t           st;
  logic             flap_q;
  logic [9:0]       px_a_r;
  logic [9:0]       px_b_r;
  logic             passed_a;
  logic             passed_b;
  logic [DIE_W-1:0] die_cnt;
  logic             hit_r;

  logic             flap_rise;
  logic [9:0]       nx_a;
  logic [9:0]       nx_b;
  logic             wrap_a;
  logic             wrap_b;
  logic signed [10:0] y_s;
  logic signed [10:0] gap_a;
  logic signed [10:0] gap_b;
  logic             hit_a;
  logic             hit_b;
  logic             hit_ground;
  logic             any_hit;
  logic             pass_a;
  logic             pass_b;
  logic             play_tick;
  logic             score_req;
  logic             score_clr;
  logic [11:0]      score;
  logic             score_done;

  // Overlap and opening test against one pillar, all in 11-bit signed space.
  function automatic logic pipe_hit(input logic signed [10:0] x,
                                    input logic signed [10:0] y,
                                    input logic signed [10:0] gap);
    logic ovl;
    ovl = (x < BIRD_X_S + BIRD_W_S) && (x + PIPE_W_S > BIRD_X_S);
    return ovl && ((y < gap - GAP_HALF_S) || (y + BIRD_W_S > gap + GAP_HALF_S));
  endfunction

  function automatic logic pipe_behind(input logic signed [10:0] x);
    return (x + PIPE_W_S <= BIRD_X_S);
  endfunction

  always_comb begin
    flap_rise  = bus.flap & ~flap_q;
    wrap_a     = (px_a_r < SCROLL_X);
    wrap_b     = (px_b_r < SCROLL_X);
    nx_a       = wrap_a ? SCREEN_X : (px_a_r - SCROLL_X);
    nx_b       = wrap_b ? SCREEN_X : (px_b_r - SCROLL_X);
    y_s        = {{2{bus.bird_y[8]}}, bus.bird_y};
    gap_a      = {2'b00, bus.p1};
    gap_b      = {2'b00, bus.p2};
    hit_a      = pipe_hit({1'b0, nx_a}, y_s, gap_a);
    hit_b      = pipe_hit({1'b0, nx_b}, y_s, gap_b);
    hit_ground = (y_s <= GROUND_S);
    any_hit    = hit_a | hit_b | hit_ground;
    pass_a     = pipe_behind({1'b0, nx_a}) && !passed_a;
    pass_b     = pipe_behind({1'b0, nx_b}) && !passed_b;
    play_tick  = (st == ST_PLAY) && bus.tick;
    // A collision on the same tick as a pass cancels the point.
    score_req  = play_tick && (pass_a || pass_b) && !any_hit;
    score_clr  = (st == ST_OVER) && flap_rise;
  end

  bcd_counter3 u_score (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (score_clr),
    .inc      (score_req),
    .value    (score),
    .inc_done (score_done)
  );

`ifdef HISCORE_EN
  logic [11:0] hiscore;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st       <= ST_READY;
      flap_q   <= 1'b0;
      px_a_r   <= SCREEN_X;
      px_b_r   <= START_B;
      passed_a <= 1'b0;
      passed_b <= 1'b0;
      die_cnt  <= '0;
      hit_r    <= 1'b0;
`ifdef HISCORE_EN
      hiscore  <= 12'h000;
`endif
    end else begin
      flap_q <= bus.flap;
      hit_r  <= 1'b0;
      case (st)
        ST_READY: begin
          if (flap_rise) st <= ST_PLAY;
        end
        ST_PLAY: begin
          if (bus.tick) begin
            px_a_r <= nx_a;
            px_b_r <= nx_b;
            if (wrap_a)                 passed_a <= 1'b0;
            else if (pass_a && !any_hit) passed_a <= 1'b1;
            if (wrap_b)                 passed_b <= 1'b0;
            else if (pass_b && !any_hit) passed_b <= 1'b1;
            if (any_hit) begin
              hit_r   <= 1'b1;
              st      <= ST_DYING;
              die_cnt <= '0;
            end
          end
        end
        ST_DYING: begin
          if (bus.tick) begin
            if (die_cnt == DIE_LAST) begin
              st <= ST_OVER;
`ifdef HISCORE_EN
              if (score > hiscore) hiscore <= score;
`endif
            end else begin
              die_cnt <= die_cnt + 1'b1;
            end
          end
        end
        ST_OVER: begin
          // Rising edge (not level) so a button held through DYING cannot skip OVER.
          if (flap_rise) begin
            st       <= ST_READY;
            px_a_r   <= SCREEN_X;
            px_b_r   <= START_B;
            passed_a <= 1'b0;
            passed_b <= 1'b0;
          end
        end
        default: st <= ST_READY;
      endcase
    end
  end

  assign bus.px_a      = px_a_r;
  assign bus.px_b      = px_b_r;
  assign bus.state     = st;
  assign bus.freeze    = (st != ST_PLAY);
  assign bus.hit       = hit_r;
  assign bus.score_inc = score_done;
  assign bus.score_bcd = score;
`ifdef HISCORE_EN
  assign bus.hiscore_bcd = hiscore;
`endif

endmodule

// File: tb/tb_pillar_collide.sv
// Directed bench for pillar_collide: hit/score pulses are scoreboarded, levels checked directly.
// Hand-derived positions assume default geometry (pillar B starts at 320, A at 640, 2 px per tick).
module tb_pillar_collide;
  import pillar_collide_pkg::*;

  localparam int W = 26;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pillar_collide_if bus ();

  pillar_collide dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic        bcd_clr;
  logic        bcd_inc;
  logic [11:0] bcd_val;
  logic        bcd_done;

  bcd_counter3 u_bcd (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (bcd_clr),
    .inc      (bcd_inc),
    .value    (bcd_val),
    .inc_done (bcd_done)
  );

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [W-1:0] ev(input logic h, input logic inc,
                                      input logic [11:0] sc, input logic [1:0] st,
                                      input logic [9:0] pxa);
    return {h, inc, sc, st, pxa};
  endfunction

  // Monitor: every hit or score_inc pulse must match the oldest expected event.
  logic [W-1:0] mon_act;
  logic [W-1:0] mon_exp;
  always @(negedge clk) begin
    if (rst_n && (bus.hit || bus.score_inc)) begin
      mon_act = {bus.hit, bus.score_inc, bus.score_bcd, bus.state, bus.px_a};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL event: unexpected {hit,inc,score,state,px_a}=%h, none expected", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          n_err++;
          $display("FAIL event: got {hit,inc,score,state,px_a}=%h expected %h", mon_act, mon_exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_ticks(input int n);
    repeat (n) begin
      bus.tick = 1'b1;
      cyc(1);
      bus.tick = 1'b0;
      cyc(1);
    end
  endtask

  task automatic start_round;
    bus.flap = 1'b0;
    cyc(1);
    bus.flap = 1'b1;
    cyc(1);
    bus.flap = 1'b0;
    cyc(1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_state"}, bus.state, ST_READY);
    check({tag, "_freeze"}, bus.freeze, 1'b1);
    check({tag, "_score"}, bus.score_bcd, 12'h000);
    check({tag, "_px_a"}, bus.px_a, 10'd640);
    check({tag, "_px_b"}, bus.px_b, 10'd320);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tick   = 1'b0;
    bus.flap   = 1'b0;
    bus.bird_y = 9'd240;
    bus.p1     = 9'd240;
    bus.p2     = 9'd240;
    bcd_clr    = 1'b0;
    bcd_inc    = 1'b0;
    rst_n      = 1'b0;
    cyc(2);
    rst_n = 1'b1;

    // Reset state and READY -> PLAY on a flap edge
    check_idle("reset");
    check("reset_hit", bus.hit, 1'b0);
    check("reset_score_inc", bus.score_inc, 1'b0);
`ifdef HISCORE_EN
    check("reset_hiscore", bus.hiscore_bcd, 12'h000);
`endif
    do_ticks(3);
    check("ready_px_a_held", bus.px_a, 10'd640);
    bus.flap = 1'b1;
    check("ready_before_edge", bus.state, ST_READY);
    cyc(1);
    check("play_state", bus.state, ST_PLAY);
    check("play_freeze", bus.freeze, 1'b0);
    check("play_px_a", bus.px_a, 10'd640);
    check("play_score", bus.score_bcd, 12'h000);
    bus.flap = 1'b0;
    cyc(1);

    // Safe flight for 400 ticks: B passes at tick 104, A at tick 264
    exp_q.push_back(ev(1'b0, 1'b1, 12'h001, ST_PLAY, 10'd432));
    do_ticks(104);
    check("pass1_score", bus.score_bcd, 12'h001);
    exp_q.push_back(ev(1'b0, 1'b1, 12'h002, ST_PLAY, 10'd112));
    do_ticks(160);
    do_ticks(136);
    check("fly400_state", bus.state, ST_PLAY);
    check("fly400_score", bus.score_bcd, 12'h002);
    check("fly400_px_a", bus.px_a, 10'd482);
    check("fly400_px_b", bus.px_b, 10'd162);

    // Pillar A hit below the opening; B opening moved to keep B safe
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    check_idle("rst_play");
    bus.bird_y = 9'd100;
    bus.p1     = 9'd240;
    bus.p2     = 9'd100;
    start_round;
    exp_q.push_back(ev(1'b0, 1'b1, 12'h001, ST_PLAY, 10'd432));
    do_ticks(104);
    exp_q.push_back(ev(1'b1, 1'b0, 12'h001, ST_DYING, 10'd174));
    do_ticks(129);
    check("hitA_state", bus.state, ST_DYING);
    check("hitA_freeze", bus.freeze, 1'b1);
    check("hitA_px_a", bus.px_a, 10'd174);
    check("hitA_px_b", bus.px_b, 10'd496);
    do_ticks(5);
    check("dying_px_a_frozen", bus.px_a, 10'd174);
    check("dying_px_b_frozen", bus.px_b, 10'd496);
    check("dying_score", bus.score_bcd, 12'h001);

    // Reset during DYING with a coincident tick: reset wins
    bus.tick = 1'b1;
    rst_n    = 1'b0;
    cyc(1);
    bus.tick = 1'b0;
    rst_n    = 1'b1;
    check_idle("rst_dying");

    // Ground hit on the same tick B would pass: no point, then DYING -> OVER
    bus.bird_y = 9'd240;
    bus.p1     = 9'd240;
    bus.p2     = 9'd240;
    start_round;
    do_ticks(103);
    bus.bird_y = 9'd0;
    exp_q.push_back(ev(1'b1, 1'b0, 12'h000, ST_DYING, 10'd432));
    do_ticks(1);
    check("ground_score", bus.score_bcd, 12'h000);
    bus.bird_y = 9'd240;
    bus.flap   = 1'b1;
    do_ticks(59);
    check("die59_state", bus.state, ST_DYING);
    do_ticks(1);
    check("die60_state", bus.state, ST_OVER);
    check("over_freeze", bus.freeze, 1'b1);
    cyc(4);
    check("over_flap_held", bus.state, ST_OVER);
    bus.flap = 1'b0;
    cyc(1);
    check("over_flap_low", bus.state, ST_OVER);
    bus.flap = 1'b1;
    cyc(1);
    check_idle("over_restart");
    bus.flap = 1'b0;
    cyc(1);

`ifdef HISCORE_EN
    // Round ending at 002 sets the high score; a later round at 001 leaves it
    start_round;
    exp_q.push_back(ev(1'b0, 1'b1, 12'h001, ST_PLAY, 10'd432));
    do_ticks(104);
    exp_q.push_back(ev(1'b0, 1'b1, 12'h002, ST_PLAY, 10'd112));
    do_ticks(160);
    bus.bird_y = 9'd0;
    exp_q.push_back(ev(1'b1, 1'b0, 12'h002, ST_DYING, 10'd110));
    do_ticks(1);
    bus.bird_y = 9'd240;
    do_ticks(60);
    check("hs1_state", bus.state, ST_OVER);
    check("hs1_hiscore", bus.hiscore_bcd, 12'h002);
    start_round;
    check("hs1_reload_hiscore", bus.hiscore_bcd, 12'h002);
    start_round;
    exp_q.push_back(ev(1'b0, 1'b1, 12'h001, ST_PLAY, 10'd432));
    do_ticks(104);
    bus.bird_y = 9'd0;
    exp_q.push_back(ev(1'b1, 1'b0, 12'h001, ST_DYING, 10'd430));
    do_ticks(1);
    bus.bird_y = 9'd240;
    do_ticks(60);
    check("hs2_state", bus.state, ST_OVER);
    check("hs2_hiscore", bus.hiscore_bcd, 12'h002);
`endif

    // Score counter carries and saturation at 999
    bcd_clr = 1'b1;
    cyc(1);
    bcd_clr = 1'b0;
    check("bcd_clear", bcd_val, 12'h000);
    bcd_inc = 1'b1;
    cyc(9);
    check("bcd_009", bcd_val, 12'h009);
    cyc(1);
    check("bcd_010", bcd_val, 12'h010);
    cyc(89);
    check("bcd_099", bcd_val, 12'h099);
    cyc(1);
    check("bcd_100", bcd_val, 12'h100);
    cyc(898);
    check("bcd_998", bcd_val, 12'h998);
    cyc(1);
    check("bcd_999", bcd_val, 12'h999);
    check("bcd_999_pulse", bcd_done, 1'b1);
    cyc(1);
    check("bcd_sat", bcd_val, 12'h999);
    check("bcd_sat_no_pulse", bcd_done, 1'b0);
    bcd_inc = 1'b0;
    cyc(2);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL event_drain: %0d expected events never seen, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
